// File: rtl/serial_pkg.sv
// Shared definitions for the serial front-end stages (serializer and the
// stages that consume its bit stream).
package serial_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/msb_serializer.sv
// Parallel-to-serial converter, MSB first, feeding divide_by_3.x_i.
// Words arrive over valid/ready; a new word may be accepted in the last-bit
// cycle of the current one, so consecutive words stream without a gap.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word in flight, outputs quiet, ready_o=1
//   SHIFT | emitting one bit per cycle; ready_o=1 only on the LSB cycle
//
module msb_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             x_vld_o,
  output logic             first_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ser_state_t       state;
  // Holds only the bits not yet emitted; the bit on x_o already left it.
  logic [WIDTH-2:0] shreg;
  // Bits still to come after the one currently on x_o.
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             take;

  assign last_bit = (cnt == '0);
  assign ready_o  = (state == IDLE) || last_bit;
  assign take     = valid_i && ready_o;

  // State: enter SHIFT on any accepted word, fall back to IDLE after an LSB with no follow-on word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else if (take) begin
      state <= SHIFT;
    end else if ((state == SHIFT) && last_bit) begin
      state <= IDLE;
    end
  end

  // Bit counter: reload on accept, count down while bits remain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= CNT_LAST;
    end else if ((state == SHIFT) && !last_bit) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Shift register: capture the remaining bits on accept, advance one bit per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= '0;
    end else if (take) begin
      shreg <= data_i[WIDTH-2:0];
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
    end
  end

  // Registered stream outputs; everything returns to 0 whenever no bit is being emitted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_o     <= 1'b0;
      x_vld_o <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else if (take) begin
      x_o     <= data_i[WIDTH-1];
      x_vld_o <= 1'b1;
      first_o <= 1'b1;
      last_o  <= 1'b0;
      busy_o  <= 1'b1;
    end else if ((state == SHIFT) && !last_bit) begin
      x_o     <= shreg[WIDTH-2];
      x_vld_o <= 1'b1;
      first_o <= 1'b0;
      last_o  <= (cnt == CNT_ONE);
      busy_o  <= 1'b1;
    end else begin
      x_o     <= 1'b0;
      x_vld_o <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
      busy_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msb_serializer.sv
// Bench for msb_serializer: a queue of pending {bit, first, last} entries
// models the stream; the head of the queue is what should be on the outputs.
module tb_msb_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         ready_o, x_o, x_vld_o, first_o, last_o, busy_o;

  int checks = 0;
  int errors = 0;

  logic [2:0] q[$];
  logic       e_x, e_vld, e_first, e_last, e_rdy, rdy_seen;

  msb_serializer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .x_o     (x_o),
    .x_vld_o (x_vld_o),
    .first_o (first_o),
    .last_o  (last_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  // One clock: drive inputs, note pre-edge ready, advance, update the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    reset   = r;
    #1;
    e_rdy    = (q.size() <= 1);
    rdy_seen = ready_o;
    @(posedge clk);
    if (!r) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (v && e_rdy)
        for (int i = W - 1; i >= 0; i--) q.push_back({d[i], 1'(i == W - 1), 1'(i == 0)});
    end
    #1;
    if (q.size() > 0) begin
      {e_x, e_first, e_last} = q[0];
      e_vld = 1'b1;
    end else begin
      {e_x, e_first, e_last} = 3'b000;
      e_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, W'($urandom), 1'b0);
      checks++;
      if ({x_o, x_vld_o, first_o, last_o, busy_o} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_outputs k=%0d got=%b exp=00000", k, {x_o, x_vld_o, first_o, last_o, busy_o});
      end
    end
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (rdy_seen !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", rdy_seen);
    end
    checks++;
    if (x_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_vld got=%b exp=0", x_vld_o);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] pat;
    pat = 8'hA5;
    cycle(1'b1, pat, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if ({x_o, x_vld_o, first_o, last_o, busy_o} !== {e_x, e_vld, e_first, e_last, e_vld}) begin
        errors++;
        $display("FAIL single_model k=%0d got=%b exp=%b", k, {x_o, x_vld_o, first_o, last_o, busy_o},
                 {e_x, e_vld, e_first, e_last, e_vld});
      end
      checks++;
      if (x_vld_o !== 1'(k <= 8)) begin
        errors++;
        $display("FAIL single_vld k=%0d got=%b exp=%b", k, x_vld_o, 1'(k <= 8));
      end
      if (k <= 8) begin
        checks++;
        if ({x_o, first_o, last_o} !== {pat[8-k], 1'(k == 1), 1'(k == 8)}) begin
          errors++;
          $display("FAIL single_bit k=%0d got=%b exp=%b", k, {x_o, first_o, last_o},
                   {pat[8-k], 1'(k == 1), 1'(k == 8)});
        end
      end
      cycle(1'b0, W'($urandom), 1'b1);
      checks++;
      if (rdy_seen !== 1'(k >= 8)) begin
        errors++;
        $display("FAIL single_ready k=%0d got=%b exp=%b", k, rdy_seen, 1'(k >= 8));
      end
    end
  endtask

  // Sends w0 then w1 with valid held high; returns the 16 observed bits and framing masks.
  task automatic send_pair(input logic [W-1:0] w0, input logic [W-1:0] w1, input string tag,
                           output logic [15:0] stream, output logic [15:0] fm, output logic [15:0] lm,
                           output int vcount, output int span);
    int nacc, firstc, lastc;
    logic v;
    stream = '0; fm = '0; lm = '0; vcount = 0; firstc = -1; lastc = -1;
    cycle(1'b1, w0, 1'b1);
    nacc = (e_rdy) ? 1 : 0;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if ({x_o, x_vld_o, first_o, last_o, busy_o} !== {e_x, e_vld, e_first, e_last, e_vld}) begin
        errors++;
        $display("FAIL %s_model c=%0d got=%b exp=%b", tag, c, {x_o, x_vld_o, first_o, last_o, busy_o},
                 {e_x, e_vld, e_first, e_last, e_vld});
      end
      if (x_vld_o === 1'b1) begin
        stream = {stream[14:0], x_o};
        fm     = {fm[14:0], first_o};
        lm     = {lm[14:0], last_o};
        vcount++;
        if (firstc < 0) firstc = c;
        lastc = c;
      end
      v = (nacc < 2);
      cycle(v, w1, 1'b1);
      checks++;
      if (rdy_seen !== e_rdy) begin
        errors++;
        $display("FAIL %s_ready c=%0d got=%b exp=%b", tag, c, rdy_seen, e_rdy);
      end
      if (v && e_rdy) nacc++;
    end
    span = (firstc < 0) ? 0 : lastc - firstc + 1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] s, fm, lm;
    int vc, span;
    send_pair(8'hFF, 8'h00, "b2b", s, fm, lm, vc, span);
    checks++;
    if (vc !== 16 || span !== 16) begin
      errors++;
      $display("FAIL b2b_contiguous got=count %0d span %0d exp=16 16", vc, span);
    end
    checks++;
    if (s !== 16'hFF00) begin
      errors++;
      $display("FAIL b2b_bits got=%h exp=ff00", s);
    end
    checks++;
    if (fm !== 16'h8080 || lm !== 16'h0101) begin
      errors++;
      $display("FAIL b2b_framing got=%h/%h exp=8080/0101", fm, lm);
    end
  endtask

  task automatic test_held_valid();
    logic [W-1:0] got;
    got = '0;
    cycle(1'b1, 8'h3C, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({x_o, x_vld_o, first_o, last_o, busy_o} !== {e_x, e_vld, e_first, e_last, e_vld}) begin
        errors++;
        $display("FAIL held_model k=%0d got=%b exp=%b", k, {x_o, x_vld_o, first_o, last_o, busy_o},
                 {e_x, e_vld, e_first, e_last, e_vld});
      end
      got = {got[W-2:0], x_o};
      cycle(1'b1, W'($urandom), 1'b1);
      checks++;
      if (rdy_seen !== 1'(k == 8)) begin
        errors++;
        $display("FAIL held_ready k=%0d got=%b exp=%b", k, rdy_seen, 1'(k == 8));
      end
    end
    checks++;
    if (got !== 8'h3C) begin
      errors++;
      $display("FAIL held_bits got=%h exp=3c", got);
    end
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, '0, 1'b1);
      checks++;
      if ({x_o, x_vld_o, first_o, last_o, busy_o} !== {e_x, e_vld, e_first, e_last, e_vld}) begin
        errors++;
        $display("FAIL held_drain k=%0d got=%b exp=%b", k, {x_o, x_vld_o, first_o, last_o, busy_o},
                 {e_x, e_vld, e_first, e_last, e_vld});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] nxt, got;
    cycle(1'b1, 8'h81, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    checks++;
    if ({x_o, x_vld_o, first_o} !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_bit3 got=%b exp=010", {x_o, x_vld_o, first_o});
    end
    cycle(1'b1, W'($urandom), 1'b0);
    checks++;
    if ({x_o, x_vld_o, first_o, last_o, busy_o} !== 5'b00000) begin
      errors++;
      $display("FAIL rstmid_outputs got=%b exp=00000", {x_o, x_vld_o, first_o, last_o, busy_o});
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got=%b exp=1", ready_o);
    end
    nxt = W'($urandom);
    got = '0;
    cycle(1'b1, nxt, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({x_o, x_vld_o, first_o, last_o, busy_o} !== {e_x, e_vld, e_first, e_last, e_vld}) begin
        errors++;
        $display("FAIL rstmid_model k=%0d got=%b exp=%b", k, {x_o, x_vld_o, first_o, last_o, busy_o},
                 {e_x, e_vld, e_first, e_last, e_vld});
      end
      got = {got[W-2:0], x_o};
      cycle(1'b0, '0, 1'b1);
    end
    checks++;
    if (got !== nxt) begin
      errors++;
      $display("FAIL rstmid_next_word got=%h exp=%h", got, nxt);
    end
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_div3();
    logic [15:0] s, fm, lm, words, vo, ve;
    int vc, span;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    words = {8'h00, 8'h03};
    send_pair(8'h00, 8'h03, "div3", s, fm, lm, vc, span);
    for (int n = 15; n <= 16; n++) begin
      vo = s >> (16 - n);
      ve = words >> (16 - n);
      checks++;
      if (1'((vo % 3) == 0) !== 1'((ve % 3) == 0)) begin
        errors++;
        $display("FAIL div3_bit%0d got=div %b (value %0d) exp=div %b (value %0d)", n,
                 1'((vo % 3) == 0), vo, 1'((ve % 3) == 0), ve);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] sent[$];
    logic [W-1:0] acc, d, exp_w;
    logic         v;
    int           nsent, ndone, nbits, budget;
    nsent = 0; ndone = 0; nbits = 0; acc = '0; budget = 0;
    while (ndone < 100 && budget < 4000) begin
      v = (nsent < 100) && ($urandom_range(0, 2) != 0);
      d = W'($urandom);
      cycle(v, d, 1'b1);
      budget++;
      checks++;
      if (rdy_seen !== e_rdy) begin
        errors++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", budget, rdy_seen, e_rdy);
      end
      if (v && e_rdy) begin
        sent.push_back(d);
        nsent++;
      end
      checks++;
      if ({x_o, x_vld_o, first_o, last_o, busy_o} !== {e_x, e_vld, e_first, e_last, e_vld}) begin
        errors++;
        $display("FAIL rand_model cyc=%0d got=%b exp=%b", budget, {x_o, x_vld_o, first_o, last_o, busy_o},
                 {e_x, e_vld, e_first, e_last, e_vld});
      end
      if (x_vld_o === 1'b1) begin
        if (first_o === 1'b1) begin
          acc = '0;
          nbits = 0;
        end
        acc = {acc[W-2:0], x_o};
        nbits++;
        if (last_o === 1'b1) begin
          exp_w = (sent.size() > 0) ? sent.pop_front() : 'x;
          checks++;
          if (acc !== exp_w || nbits != W) begin
            errors++;
            $display("FAIL rand_word idx=%0d got=%h (%0d bits) exp=%h (%0d bits)", ndone, acc, nbits, exp_w, W);
          end
          ndone++;
        end
      end
    end
    checks++;
    if (ndone != 100) begin
      errors++;
      $display("FAIL rand_budget got=%0d words exp=100 words", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1);
    test_held_valid();
    test_reset_mid();
    test_div3();
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
